// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: filtered line inputs, 11-bit frame deserialiser with
// parity/stop checking, and a small scancode FIFO that toggles an IRQ per push.
module ps2_keyboard #(
   parameter int FILTER     = 8,
   parameter int TIMEOUT    = 25000,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  CLOCK,
   input  logic                  RESET_N,
   input  logic                  PS2_CLK,
   input  logic                  PS2_DAT,
   input  logic                  I_ACK,
   output logic [7:0]            O_DATA,
   output logic                  O_READY,
   output logic [DEPTH_LOG2:0]   O_COUNT,
   output logic                  O_IRQ,
   output logic                  O_OVF,
   output logic                  O_ERR
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int FW    = $clog2(FILTER + 1);
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int CW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   function automatic logic odd_parity(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   // Line index 0 is PS2_CLK, index 1 is PS2_DAT
   logic [1:0]    s1_r, s2_r, filt_r;
   logic [FW-1:0] cnt_r [2];
   logic          clk_d_r;
   logic          fall_s, bit_s;

   // Two-flop synchroniser followed by a per-line stability filter
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         s1_r   <= 2'b11;
         s2_r   <= 2'b11;
         filt_r <= 2'b11;
         for (int i = 0; i < 2; i++) cnt_r[i] <= '0;
      end else begin
         s1_r <= {PS2_DAT, PS2_CLK};
         s2_r <= s1_r;
         for (int i = 0; i < 2; i++) begin
            if (s2_r[i] != filt_r[i]) begin
               if (cnt_r[i] == FW'(FILTER - 1)) begin
                  filt_r[i] <= s2_r[i];
                  cnt_r[i]  <= '0;
               end else begin
                  cnt_r[i] <= cnt_r[i] + FW'(1);
               end
            end else begin
               cnt_r[i] <= '0;
            end
         end
      end
   end

   // Previous filtered clock level for falling-edge detection
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) clk_d_r <= 1'b1;
      else          clk_d_r <= filt_r[0];
   end

   assign fall_s = clk_d_r & ~filt_r[0];
   assign bit_s  = filt_r[1];

   state_t        state_r, state_n;
   logic [2:0]    bitcnt_r, bitcnt_n;
   logic [7:0]    shreg_r, shreg_n;
   logic          par_r, par_n;
   logic [TW-1:0] idle_r;
   logic          err_r, err_s, push_s, timeout_s;

   assign timeout_s = (state_r != IDLE) && (idle_r == TW'(TIMEOUT));

   // Receiver next-state logic; push/error are decided on the stop-bit edge
   always_comb begin
      state_n  = state_r;
      bitcnt_n = bitcnt_r;
      shreg_n  = shreg_r;
      par_n    = par_r;
      push_s   = 1'b0;
      err_s    = 1'b0;
      if (fall_s) begin
         case (state_r)
            IDLE: begin
               if (!bit_s) begin
                  state_n  = DATA;
                  bitcnt_n = 3'd0;
               end else begin
                  state_n = IDLE;
               end
            end
            DATA: begin
               shreg_n  = {bit_s, shreg_r[7:1]};
               bitcnt_n = bitcnt_r + 3'd1;
               if (bitcnt_r == 3'd7) state_n = PARITY;
               else                  state_n = DATA;
            end
            PARITY: begin
               par_n   = bit_s;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               if (bit_s && odd_parity(shreg_r, par_r)) push_s = 1'b1;
               else                                     err_s  = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end else if (timeout_s) begin
         state_n = IDLE;
      end else begin
         state_n = state_r;
      end
   end

   // Receiver state, shift register and mid-frame idle counter
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_r  <= IDLE;
         bitcnt_r <= 3'd0;
         shreg_r  <= 8'h00;
         par_r    <= 1'b0;
         err_r    <= 1'b0;
         idle_r   <= '0;
      end else begin
         state_r  <= state_n;
         bitcnt_r <= bitcnt_n;
         shreg_r  <= shreg_n;
         par_r    <= par_n;
         err_r    <= err_s;
         if (fall_s || (state_r == IDLE) || timeout_s) idle_r <= '0;
         else                                          idle_r <= idle_r + TW'(1);
      end
   end

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr_r, rptr_r;
   logic [CW-1:0]         count_r;
   logic                  irq_r, ovf_r;
   logic                  pop_s, full_s, push_ok_s;

   assign pop_s     = I_ACK && (count_r != '0);
   assign full_s    = (count_r == CW'(DEPTH));
   // A full FIFO still accepts a byte when the head is popped in the same cycle
   assign push_ok_s = push_s && (!full_s || pop_s);

   // FIFO storage
   always_ff @(posedge CLOCK) begin
      if (push_ok_s) mem[wptr_r] <= shreg_r;
   end

   // FIFO pointers, occupancy, IRQ toggle and overflow flag
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
         irq_r   <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wptr_r <= wptr_r + DEPTH_LOG2'(1);
            irq_r  <= ~irq_r;
         end else if (push_s) begin
            ovf_r <= 1'b1;
         end
         if (pop_s) rptr_r <= rptr_r + DEPTH_LOG2'(1);
         case ({push_ok_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign O_DATA  = (count_r != '0) ? mem[rptr_r] : 8'h00;
   assign O_READY = (count_r != '0);
   assign O_COUNT = count_r;
   assign O_IRQ   = irq_r;
   assign O_OVF   = ovf_r;
   assign O_ERR   = err_r;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random frames,
// compared against a queue-based model of the scancode FIFO.
module tb_ps2_keyboard;

   localparam int FILT  = 4;
   localparam int TMO   = 600;
   localparam int HALF  = 40;
   localparam int DEPTH = 8;

   logic       clock = 1'b0;
   logic       reset_n, ps2_clk, ps2_dat, ack;
   logic [7:0] o_data;
   logic       o_ready, o_irq, o_ovf, o_err;
   logic [3:0] o_count;

   int checks = 0, errors = 0;
   int err_seen = 0, exp_err = 0;
   logic [7:0] q[$];
   logic exp_irq = 1'b0, exp_ovf = 1'b0;

   ps2_keyboard #(.FILTER(FILT), .TIMEOUT(TMO), .DEPTH_LOG2(3)) dut (
      .CLOCK(clock), .RESET_N(reset_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
      .I_ACK(ack), .O_DATA(o_data), .O_READY(o_ready), .O_COUNT(o_count),
      .O_IRQ(o_irq), .O_OVF(o_ovf), .O_ERR(o_err)
   );

   always #20 clock = ~clock;

   always @(posedge clock) if (o_err === 1'b1) err_seen++;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic par;
      par = (~^d) ^ bad_par;
      return {~bad_stop, par, d, 1'b0};
   endfunction

   task automatic check_state(input string tag);
      logic [7:0] head;
      head = (q.size() > 0) ? q[0] : 8'h00;
      check_value({tag, "/count"}, 32'(o_count), 32'(q.size()));
      check_value({tag, "/ready"}, 32'(o_ready), 32'(q.size() > 0));
      check_value({tag, "/data"},  32'(o_data),  32'(head));
      check_value({tag, "/irq"},   32'(o_irq),   32'(exp_irq));
      check_value({tag, "/ovf"},   32'(o_ovf),   32'(exp_ovf));
      check_value({tag, "/errcnt"}, 32'(err_seen), 32'(exp_err));
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit ack_stop);
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = bits[i];
         repeat (HALF) @(negedge clock);
         ps2_clk = 1'b0;
         if (ack_stop && i == 10) begin
            // edge seen 2+FILT cycles after the raw fall; push on the next edge
            repeat (FILT + 2) @(negedge clock);
            ack = 1'b1;
            @(negedge clock);
            ack = 1'b0;
            repeat (HALF - FILT - 3) @(negedge clock);
         end else begin
            repeat (HALF) @(negedge clock);
         end
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clock);
   endtask

   task automatic frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input bit ack_stop);
      send_bits(make_frame(d, bad_par, bad_stop), 11, ack_stop);
      if (bad_par || bad_stop) begin
         exp_err++;
         if (ack_stop && q.size() > 0) void'(q.pop_front());
      end else if (ack_stop && q.size() > 0) begin
         void'(q.pop_front());
         q.push_back(d);
         exp_irq = ~exp_irq;
      end else if (q.size() < DEPTH) begin
         q.push_back(d);
         exp_irq = ~exp_irq;
      end else begin
         exp_ovf = 1'b1;
      end
   endtask

   task automatic pop_one(input string tag);
      logic [7:0] head;
      head = (q.size() > 0) ? q[0] : 8'h00;
      check_value({tag, "/head"}, 32'(o_data), 32'(head));
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      q.delete();
      exp_irq = 1'b0;
      exp_ovf = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      int kind, npop;
      reset_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; ack = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_state("reset");

      frame(8'h1C, 1'b0, 1'b0, 1'b0);
      check_state("valid_1c");
      pop_one("pop_1c");
      check_state("after_pop");
      pop_one("pop_empty");
      check_state("pop_empty");

      frame(8'h1C, 1'b1, 1'b0, 1'b0);
      check_state("bad_parity");
      frame(8'h2B, 1'b0, 1'b1, 1'b0);
      check_state("bad_stop");

      for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
      check_state("overflow");
      for (int i = 0; i < 8; i++) pop_one("drain");
      check_state("drained");

      send_bits(make_frame(8'h33, 1'b0, 1'b0), 5, 1'b0);
      repeat (TMO + 10) @(negedge clock);
      check_state("stalled");
      frame(8'hF0, 1'b0, 1'b0, 1'b0);
      check_state("after_timeout");
      pop_one("pop_f0");

      ps2_dat = 1'b0;
      repeat (10) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clock);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clock);
      ps2_dat = 1'b1;
      repeat (HALF) @(negedge clock);
      check_state("glitch");
      frame(8'hA5, 1'b0, 1'b0, 1'b0);
      check_state("after_glitch");
      pop_one("pop_a5");

      for (int i = 0; i < DEPTH; i++) frame(8'($urandom), 1'b0, 1'b0, 1'b0);
      check_state("full");
      frame(8'h77, 1'b0, 1'b0, 1'b1);
      check_state("full_push_pop");
      for (int i = 0; i < DEPTH; i++) pop_one("drain_full");
      check_state("drained_full");

      frame(8'h11, 1'b0, 1'b0, 1'b0);
      frame(8'h12, 1'b0, 1'b0, 1'b0);
      send_bits(make_frame(8'h44, 1'b0, 1'b0), 5, 1'b0);
      pulse_reset();
      check_state("mid_reset");
      frame(8'h5A, 1'b0, 1'b0, 1'b0);
      check_state("after_reset");

      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         kind = $urandom_range(0, 5);
         frame(d, kind == 0, kind == 1, $urandom_range(0, 3) == 0);
         check_state("rand_frame");
         npop = $urandom_range(0, 2);
         for (int k = 0; k < npop; k++) pop_one("rand_pop");
         check_state("rand_pop");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
